// File: rtl/ir_cam_sequencer.sv
// ============================================================================
// ir_cam_sequencer
// ----------------------------------------------------------------------------
// Command sequencer that sits in front of i2c_master and paces every
// transaction it sees. After `enable` it replays a six-entry write table that
// initialises the IR camera at 7-bit address 0x58. When polling is compiled
// in, it then alternates a one-byte write of 0x36 with a READ_BYTES read,
// once per POLL_CYCLES.
//
// Compile-time option:
//   IR_CAM_POLL_EN  defined   -> POLL_WAIT state, poll timer and poll_valid
//                               are built in.
//                   undefined -> after init the FSM parks in DONE until reset,
//                               and poll_valid is tied low.
//
// Parameters:
//   GAP_CYCLES   idle cycles after every completed transaction (>= 1)
//   POLL_CYCLES  poll period, measured from one poll-write start to the next
//   READ_BYTES   packets value for the poll read (1..31)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       starts the sequence (sampled in IDLE); gates polls in POLL_WAIT
//   i2c_ready    ready from i2c_master
//   i2c_start    one-cycle start request to i2c_master
//   i2c_rw       0 = write, 1 = read
//   i2c_packets  byte count of the current transaction
//   i2c_addr     constant camera address 7'h58
//   i2c_data     write payload, byte k at [k*8 +: 8], byte 0 sent first
//   init_done    sticky, set once all six init writes have completed
//   poll_valid   one-cycle pulse when a poll read completes
//   busy         high whenever the FSM is not IDLE, DONE or POLL_WAIT
// ============================================================================
module ir_cam_sequencer #(
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned POLL_CYCLES = 100000,
    parameter int unsigned READ_BYTES  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        i2c_ready,
    output logic        i2c_start,
    output logic        i2c_rw,
    output logic [4:0]  i2c_packets,
    output logic [6:0]  i2c_addr,
    output logic [95:0] i2c_data,
    output logic        init_done,
    output logic        poll_valid,
    output logic        busy
);

    // Out-of-range parameters would make the gap counter or read length
    // meaningless, so refuse to elaborate with them.
    if (GAP_CYCLES < 1 || READ_BYTES < 1 || READ_BYTES > 31 || POLL_CYCLES < 1) begin : g_param_check
        $error("ir_cam_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_BUSY      = 3'd2,
        ST_DONE_WAIT = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5,
        ST_POLL_WAIT = 3'd6
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  packets;
        logic [95:0] data;
    } cmd_t;

    // Command pointer: 0..5 are the init table, 6/7 are the poll write/read.
    localparam logic [2:0]  CMD_LAST_INIT = 3'd5;
    localparam logic [2:0]  CMD_POLL_WR   = 3'd6;
    localparam logic [2:0]  CMD_POLL_RD   = 3'd7;
    localparam logic [31:0] GAP_LAST      = 32'(GAP_CYCLES - 1);

`ifdef IR_CAM_POLL_EN
    localparam state_t ST_AFTER_INIT = ST_POLL_WAIT;
`else
    localparam state_t ST_AFTER_INIT = ST_DONE;
`endif

    // Fixed command ROM; every unused data bit stays 0.
    function automatic cmd_t cmd_lookup(input logic [2:0] idx);
        cmd_t c;
        c = '0;
        case (idx)
            3'd0:    begin c.packets = 5'd2; c.data[15:0] = 16'h0130; end
            3'd1:    begin c.packets = 5'd2; c.data[15:0] = 16'h0830; end
            3'd2:    begin c.packets = 5'd2; c.data[15:0] = 16'h9006; end
            3'd3:    begin c.packets = 5'd2; c.data[15:0] = 16'hC008; end
            3'd4:    begin c.packets = 5'd2; c.data[15:0] = 16'h401A; end
            3'd5:    begin c.packets = 5'd2; c.data[15:0] = 16'h3333; end
            3'd6:    begin c.packets = 5'd1; c.data[7:0]  = 8'h36;    end
            3'd7:    begin c.rw = 1'b1; c.packets = 5'(READ_BYTES);    end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_q,     state_d;
    logic [2:0]  cmd_idx_q,   cmd_idx_d;
    cmd_t        cmd_q,       cmd_d;
    logic [31:0] gap_cnt_q,   gap_cnt_d;
    logic        start_q,     start_d;
    logic        init_done_q, init_done_d;
    logic        busy_q,      busy_d;
`ifdef IR_CAM_POLL_EN
    logic [31:0] poll_cnt_q,  poll_cnt_d;
    logic        poll_valid_q, poll_valid_d;
    logic        poll_expired_s;

    // The counter holds cycles elapsed since the edge after the last poll-write
    // start; the +2 lets the ISSUE decision and the start register both land
    // inside the period so consecutive starts are exactly POLL_CYCLES apart.
    assign poll_expired_s = ({1'b0, poll_cnt_q} + 33'd2) >= 33'(POLL_CYCLES);
`endif

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_d       = cmd_q;
        gap_cnt_d   = gap_cnt_q;
        start_d     = 1'b0;
        init_done_d = init_done_q;
`ifdef IR_CAM_POLL_EN
        poll_valid_d = 1'b0;
        // Saturating count so a long suspension never wraps into a false expiry.
        poll_cnt_d   = (poll_cnt_q == 32'hFFFF_FFFF) ? poll_cnt_q : (poll_cnt_q + 32'd1);
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    cmd_idx_d = 3'd0;
                    cmd_d     = cmd_lookup(3'd0);
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i2c_ready) begin
                    start_d = 1'b1;
                    state_d = ST_BUSY;
`ifdef IR_CAM_POLL_EN
                    if (cmd_idx_q == CMD_POLL_WR) begin
                        poll_cnt_d = 32'd0;
                    end else begin
                        poll_cnt_d = poll_cnt_d;
                    end
`endif
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                // Wait for the master to acknowledge by dropping ready.
                if (!i2c_ready) begin
                    state_d = ST_DONE_WAIT;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE_WAIT: begin
                if (i2c_ready) begin
                    gap_cnt_d = 32'd0;
                    state_d   = ST_GAP;
`ifdef IR_CAM_POLL_EN
                    poll_valid_d = (cmd_idx_q == CMD_POLL_RD);
`endif
                end else begin
                    state_d = ST_DONE_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    case (cmd_idx_q)
                        CMD_LAST_INIT: begin
                            init_done_d = 1'b1;
                            state_d     = ST_AFTER_INIT;
                        end
`ifdef IR_CAM_POLL_EN
                        CMD_POLL_WR: begin
                            cmd_idx_d = CMD_POLL_RD;
                            cmd_d     = cmd_lookup(CMD_POLL_RD);
                            state_d   = ST_ISSUE;
                        end
                        CMD_POLL_RD: begin
                            state_d   = ST_POLL_WAIT;
                        end
`endif
                        default: begin
                            cmd_idx_d = cmd_idx_q + 3'd1;
                            cmd_d     = cmd_lookup(cmd_idx_q + 3'd1);
                            state_d   = ST_ISSUE;
                        end
                    endcase
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
`ifdef IR_CAM_POLL_EN
            ST_POLL_WAIT: begin
                // Dropping enable here suspends polling until it returns.
                if (enable && poll_expired_s) begin
                    cmd_idx_d = CMD_POLL_WR;
                    cmd_d     = cmd_lookup(CMD_POLL_WR);
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_POLL_WAIT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_POLL_WAIT));
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_idx_q    <= 3'd0;
            cmd_q        <= '0;
            gap_cnt_q    <= 32'd0;
            start_q      <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef IR_CAM_POLL_EN
            poll_cnt_q   <= 32'd0;
            poll_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_idx_q    <= cmd_idx_d;
            cmd_q        <= cmd_d;
            gap_cnt_q    <= gap_cnt_d;
            start_q      <= start_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
`ifdef IR_CAM_POLL_EN
            poll_cnt_q   <= poll_cnt_d;
            poll_valid_q <= poll_valid_d;
`endif
        end
    end

    assign i2c_start   = start_q;
    assign i2c_rw      = cmd_q.rw;
    assign i2c_packets = cmd_q.packets;
    assign i2c_data    = cmd_q.data;
    assign i2c_addr    = 7'h58;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
`ifdef IR_CAM_POLL_EN
    assign poll_valid  = poll_valid_q;
`else
    assign poll_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ir_cam_sequencer.sv
// ============================================================================
// tb_ir_cam_sequencer
// Directed bench for ir_cam_sequencer. The initial block plays the role of
// i2c_master: after each start it keeps ready high for two cycles, drops it
// for 40 cycles, then raises it again. Outputs are sampled on the falling
// clock edge.
// ============================================================================
module tb_ir_cam_sequencer;

    localparam int GAP  = 20;
    localparam int POLL = 500;
    localparam int RB   = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        i2c_ready;
    logic        i2c_start;
    logic        i2c_rw;
    logic [4:0]  i2c_packets;
    logic [6:0]  i2c_addr;
    logic [95:0] i2c_data;
    logic        init_done;
    logic        poll_valid;
    logic        busy;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int unsigned cyc    = 0;
    int unsigned last_rise;
    int unsigned start_time;
    bit          have_rise;
    int          n_starts;

    logic [15:0] init_tab [6] = '{16'h0130, 16'h0830, 16'h9006, 16'hC008, 16'h401A, 16'h3333};

    ir_cam_sequencer #(
        .GAP_CYCLES (GAP),
        .POLL_CYCLES(POLL),
        .READ_BYTES (RB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .i2c_ready  (i2c_ready),
        .i2c_start  (i2c_start),
        .i2c_rw     (i2c_rw),
        .i2c_packets(i2c_packets),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .init_done  (init_done),
        .poll_valid (poll_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [15:0] d, input logic rw, input logic [4:0] pk);
        check({tag, " rw"}, 96'(i2c_rw), 96'(rw));
        check({tag, " packets"}, 96'(i2c_packets), 96'(pk));
        check({tag, " data"}, i2c_data, {80'd0, d});
        check({tag, " addr"}, 96'(i2c_addr), 96'h58);
    endtask

    // Called on the negedge where i2c_start was seen high.
    task automatic finish_txn(input string tag, input logic exp_pv);
        start_time = cyc;
        n_starts++;
        if (have_rise) check({tag, " gap"}, 96'((cyc - last_rise) >= GAP), 96'd1);
        @(negedge clk);
        check({tag, " start width"}, 96'(i2c_start), 96'd0);
        @(negedge clk);
        i2c_ready = 1'b0;
        repeat (40) @(negedge clk);
        i2c_ready = 1'b1;
        last_rise = cyc;
        have_rise = 1'b1;
        @(negedge clk);
        check({tag, " poll_valid"}, 96'(poll_valid), 96'(exp_pv));
        @(negedge clk);
        check({tag, " poll_valid drop"}, 96'(poll_valid), 96'd0);
    endtask

    task automatic wait_start(input string tag, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (i2c_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, " start seen"}, 96'(found), 96'd1);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] d, input logic rw,
                           input logic [4:0] pk, input logic exp_pv);
        bit found;
        wait_start(tag, 2000, found);
        if (found) begin
            check_fields(tag, d, rw, pk);
            finish_txn(tag, exp_pv);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " start"},      96'(i2c_start),   96'd0);
        check({tag, " rw"},         96'(i2c_rw),      96'd0);
        check({tag, " packets"},    96'(i2c_packets), 96'd0);
        check({tag, " data"},       i2c_data,         96'd0);
        check({tag, " addr"},       96'(i2c_addr),    96'h58);
        check({tag, " init_done"},  96'(init_done),   96'd0);
        check({tag, " poll_valid"}, 96'(poll_valid),  96'd0);
        check({tag, " busy"},       96'(busy),        96'd0);
    endtask

    initial begin
        bit found;
        bit seen;
        int unsigned t1;
        int extra;

        reset     = 1'b1;
        enable    = 1'b0;
        i2c_ready = 1'b1;
        have_rise = 1'b0;
        n_starts  = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Enable with the master not ready: ISSUE must hold without a pulse.
        reset     = 1'b0;
        i2c_ready = 1'b0;
        enable    = 1'b1;
        @(negedge clk);
        check("issue busy", 96'(busy), 96'd1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (i2c_start === 1'b1) seen = 1'b1;
        end
        check("hold no start", 96'(seen), 96'd0);
        i2c_ready = 1'b1;
        @(negedge clk);
        check("start after ready", 96'(i2c_start), 96'd1);
        check_fields("init0", init_tab[0], 1'b0, 5'd2);
        finish_txn("init0", 1'b0);

        run_txn("init1", init_tab[1], 1'b0, 5'd2, 1'b0);

        // Third write: reset while the FSM is in BUSY.
        wait_start("init2", 2000, found);
        if (found) check_fields("init2", init_tab[2], 1'b0, 5'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");

        // Restart from entry 0; start appears two edges after enable is seen.
        have_rise = 1'b0;
        n_starts  = 0;
        reset     = 1'b0;
        @(negedge clk);
        check("restart t+1 start", 96'(i2c_start), 96'd0);
        check("restart t+1 busy", 96'(busy), 96'd1);
        @(negedge clk);
        check("restart t+2 start", 96'(i2c_start), 96'd1);
        check_fields("restart0", init_tab[0], 1'b0, 5'd2);
        enable = 1'b0;
        finish_txn("restart0", 1'b0);

        for (int n = 1; n < 6; n++) begin
            if (n == 5) check("init_done before last", 96'(init_done), 96'd0);
            run_txn($sformatf("init%0d", n), init_tab[n], 1'b0, 5'd2, 1'b0);
        end
        // finish_txn ended two negedges after the last ready rise.
        repeat (GAP - 2) @(negedge clk);
        check("init_done at gap end", 96'(init_done), 96'd0);
        @(negedge clk);
        check("init_done rises", 96'(init_done), 96'd1);
        check("idle busy after init", 96'(busy), 96'd0);

`ifdef IR_CAM_POLL_EN
        // enable low in POLL_WAIT suspends polls.
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (i2c_start === 1'b1) seen = 1'b1;
        end
        check("suspended no start", 96'(seen), 96'd0);
        enable = 1'b1;
        run_txn("poll wr a", 16'h0036, 1'b0, 5'd1, 1'b0);
        t1 = start_time;
        run_txn("poll rd a", 16'h0000, 1'b1, 5'(RB), 1'b1);
        run_txn("poll wr b", 16'h0036, 1'b0, 5'd1, 1'b0);
        check("poll period 1", 96'(start_time - t1), 96'(POLL));
        t1 = start_time;
        run_txn("poll rd b", 16'h0000, 1'b1, 5'(RB), 1'b1);
        run_txn("poll wr c", 16'h0036, 1'b0, 5'd1, 1'b0);
        check("poll period 2", 96'(start_time - t1), 96'(POLL));
        check("init_done sticky", 96'(init_done), 96'd1);
`else
        // Parked in DONE: nothing more, even with enable high again.
        enable = 1'b1;
        extra  = 0;
        seen   = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (i2c_start === 1'b1) extra++;
            if (poll_valid === 1'b1) seen = 1'b1;
        end
        check("total starts", 96'(n_starts + extra), 96'd6);
        check("poll_valid never", 96'(seen), 96'd0);
        check("done busy", 96'(busy), 96'd0);
        check("init_done sticky", 96'(init_done), 96'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
